// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor_gshare
// Brief   : Saturating-counter PHT, bimodal or gshare, with clocked table clear
//           and a speculative GHR repaired on mispredict. BP_STATS_EN adds
//           branch / mispredict counters.
// Revision: 1.0
// ============================================================================
module branch_predictor_gshare #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int INDEX_BITS    = 7,
  parameter int CTR_BITS      = 2,
  parameter int HIST_BITS     = 7,
  parameter int MODE          = 1
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic [ADDRESS_WIDTH-1:0] i_IMEM_address,
  input  logic                     i_IMEM_isbranch,
  input  logic                     i_ALU_isbranch,
  input  logic                     i_ALU_outcome,
  input  logic [ADDRESS_WIDTH-1:0] i_ALU_pc,
  input  logic                     i_ALU_prediction,
  input  logic [HIST_BITS-1:0]     i_ALU_ghr,
  output logic                     o_taken,
  output logic                     o_valid,
  output logic                     o_flush,
  output logic [HIST_BITS-1:0]     o_ghr,
  output logic                     o_ready
`ifdef BP_STATS_EN
  ,
  output logic [31:0]              o_stat_branches,
  output logic [31:0]              o_stat_mispredicts
`endif
);

  localparam int                  c_DEPTH      = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] c_WEAK_TAKEN = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] c_CTR_MAX    = '1;
  localparam logic [CTR_BITS-1:0] c_CTR_ONE    = {{(CTR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [INDEX_BITS-1:0] r_clr_ptr;
  logic [HIST_BITS-1:0]  r_ghr;
  logic [CTR_BITS-1:0]   r_pht [0:c_DEPTH-1];

  logic                  w_run;
  logic [INDEX_BITS-1:0] w_fetch_idx;
  logic [INDEX_BITS-1:0] w_res_idx;
  logic [CTR_BITS-1:0]   w_fetch_ctr;
  logic [CTR_BITS-1:0]   w_res_ctr;
  logic                  w_we;
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic [CTR_BITS-1:0]   w_wr_data;
  logic                  w_unused;

  generate
    if (MODE == 1) begin : g_gshare
      assign w_fetch_idx = i_IMEM_address[INDEX_BITS-1:0] ^ INDEX_BITS'(r_ghr);
      assign w_res_idx   = i_ALU_pc[INDEX_BITS-1:0] ^ INDEX_BITS'(i_ALU_ghr);
    end else begin : g_bimodal
      assign w_fetch_idx = i_IMEM_address[INDEX_BITS-1:0];
      assign w_res_idx   = i_ALU_pc[INDEX_BITS-1:0];
    end
  endgenerate

  assign w_unused    = ^{i_IMEM_address[ADDRESS_WIDTH-1:INDEX_BITS],
                         i_ALU_pc[ADDRESS_WIDTH-1:INDEX_BITS]};

  assign w_run       = (r_state == ST_RUN);
  assign w_fetch_ctr = r_pht[w_fetch_idx];
  assign w_res_ctr   = r_pht[w_res_idx];

  assign o_ready     = w_run;
  assign o_valid     = w_run & i_IMEM_isbranch;
  assign o_taken     = o_valid & w_fetch_ctr[CTR_BITS-1];
  assign o_flush     = w_run & i_ALU_isbranch & (i_ALU_outcome != i_ALU_prediction);
  assign o_ghr       = r_ghr;

  // Single write port: the clear sequence owns it during INIT, resolution after.
  always_comb begin
    w_we      = 1'b0;
    w_wr_idx  = w_res_idx;
    w_wr_data = w_res_ctr;
    if (!w_run) begin
      w_we      = 1'b1;
      w_wr_idx  = r_clr_ptr;
      w_wr_data = c_WEAK_TAKEN;
    end else if (i_ALU_isbranch) begin
      w_we = 1'b1;
      if (i_ALU_outcome) begin
        w_wr_data = (w_res_ctr == c_CTR_MAX) ? w_res_ctr : w_res_ctr + c_CTR_ONE;
      end else begin
        w_wr_data = (w_res_ctr == '0) ? w_res_ctr : w_res_ctr - c_CTR_ONE;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_we) begin
      r_pht[w_wr_idx] <= w_wr_data;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state   <= ST_INIT;
      r_clr_ptr <= '0;
      r_ghr     <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == '1) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Repair from the branch's own snapshot beats any speculative shift.
          if (o_flush) begin
            r_ghr <= {i_ALU_ghr[HIST_BITS-2:0], i_ALU_outcome};
          end else if (o_valid) begin
            r_ghr <= {r_ghr[HIST_BITS-2:0], o_taken};
          end
        end
      endcase
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (w_run) begin
      if (i_ALU_isbranch && (r_stat_br != 32'hFFFF_FFFF)) begin
        r_stat_br <= r_stat_br + 32'd1;
      end
      if (o_flush && (r_stat_mp != 32'hFFFF_FFFF)) begin
        r_stat_mp <= r_stat_mp + 32'd1;
      end
    end
  end

  assign o_stat_branches    = r_stat_br;
  assign o_stat_mispredicts = r_stat_mp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_predictor_gshare
// Brief   : Self-checking bench driving a bimodal and a gshare instance.
// Revision: 1.0
// ============================================================================
module tb_branch_predictor_gshare;

  localparam int AW = 22;
  localparam int HB = 7;

  typedef struct packed {
    logic          f_br;
    logic [AW-1:0] f_pc;
    logic          a_br;
    logic          a_out;
    logic [AW-1:0] a_pc;
    logic          a_pred;
    logic [HB-1:0] a_ghr;
  } drv_t;

  typedef struct {
    bit            sel;
    drv_t          d;
    bit            e_valid;
    bit            e_taken;
    bit            e_flush;
    logic [HB-1:0] e_ghr;
  } vec_t;

  typedef struct {
    bit            sel;
    int            id;
    bit            e_valid;
    bit            e_taken;
    bit            e_flush;
    logic [HB-1:0] e_ghr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  drv_t in_b, in_g;
  logic taken_b, valid_b, flush_b, ready_b;
  logic taken_g, valid_g, flush_g, ready_g;
  logic [HB-1:0] ghr_b, ghr_g;
`ifdef BP_STATS_EN
  logic [31:0] st_br_b, st_mp_b, st_br_g, st_mp_g;
`endif

  vec_t vecs[$];
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.MODE(0)) dut_b (
    .i_Clk(clk), .i_Reset(rst),
    .i_IMEM_address(in_b.f_pc), .i_IMEM_isbranch(in_b.f_br),
    .i_ALU_isbranch(in_b.a_br), .i_ALU_outcome(in_b.a_out), .i_ALU_pc(in_b.a_pc),
    .i_ALU_prediction(in_b.a_pred), .i_ALU_ghr(in_b.a_ghr),
    .o_taken(taken_b), .o_valid(valid_b), .o_flush(flush_b), .o_ghr(ghr_b),
    .o_ready(ready_b)
`ifdef BP_STATS_EN
    , .o_stat_branches(st_br_b), .o_stat_mispredicts(st_mp_b)
`endif
  );

  branch_predictor_gshare #(.MODE(1)) dut_g (
    .i_Clk(clk), .i_Reset(rst),
    .i_IMEM_address(in_g.f_pc), .i_IMEM_isbranch(in_g.f_br),
    .i_ALU_isbranch(in_g.a_br), .i_ALU_outcome(in_g.a_out), .i_ALU_pc(in_g.a_pc),
    .i_ALU_prediction(in_g.a_pred), .i_ALU_ghr(in_g.a_ghr),
    .o_taken(taken_g), .o_valid(valid_g), .o_flush(flush_g), .o_ghr(ghr_g),
    .o_ready(ready_g)
`ifdef BP_STATS_EN
    , .o_stat_branches(st_br_g), .o_stat_mispredicts(st_mp_g)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(bit sel, bit fbr, int fpc, bit abr, bit aout, int apc,
                              bit apred, int aghr, bit ev, bit et, bit ef, int eg);
    vec_t v;
    v.sel      = sel;
    v.d.f_br   = fbr;
    v.d.f_pc   = AW'(fpc);
    v.d.a_br   = abr;
    v.d.a_out  = aout;
    v.d.a_pc   = AW'(apc);
    v.d.a_pred = apred;
    v.d.a_ghr  = HB'(aghr);
    v.e_valid  = ev;
    v.e_taken  = et;
    v.e_flush  = ef;
    v.e_ghr    = HB'(eg);
    return v;
  endfunction

  task automatic check_zero(input string name);
    check({name, " ready_b"}, ready_b, 0);
    check({name, " valid/taken/flush_b"}, {valid_b, taken_b, flush_b}, 0);
    check({name, " ghr_b"}, ghr_b, 0);
    check({name, " ready_g"}, ready_g, 0);
    check({name, " valid/taken/flush_g"}, {valid_g, taken_g, flush_g}, 0);
    check({name, " ghr_g"}, ghr_g, 0);
  endtask

  // Busy inputs during INIT must be ignored; count cycles until ready.
  task automatic init_stim();
    drv_t d;
    d = '0;
    d.f_br = 1'b1; d.f_pc = AW'(5);
    d.a_br = 1'b1; d.a_out = 1'b0; d.a_pc = AW'(5); d.a_pred = 1'b1; d.a_ghr = HB'(3);
    in_b = d;
    in_g = d;
  endtask

  task automatic wait_init(input string name);
    int cnt = 0;
    bit bad = 0;
    while (cnt < 400) begin
      @(negedge clk);
      if (ready_b != ready_g) bad = 1;
      if (ready_b && ready_g) break;
      if (valid_b | taken_b | flush_b | valid_g | taken_g | flush_g) bad = 1;
      if ((ghr_b != 0) || (ghr_g != 0)) bad = 1;
      cnt++;
    end
    in_b = '0;
    in_g = '0;
    check({name, " init cycles"}, cnt, 128);
    check({name, " quiet during init"}, 32'(bad), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    // bimodal: train / saturate / repair
    vecs.push_back(mk(0, 1, 'h05,     0, 0, 0,    0, 0,    1, 1, 0, 'h00));
    vecs.push_back(mk(0, 0, 0,        1, 0, 'h05, 1, 0,    0, 0, 1, 'h01));
    vecs.push_back(mk(0, 0, 0,        1, 0, 'h05, 0, 0,    0, 0, 0, 'h00));
    vecs.push_back(mk(0, 1, 'h05,     0, 0, 0,    0, 0,    1, 0, 0, 'h00));
    vecs.push_back(mk(0, 0, 0,        1, 0, 'h05, 0, 0,    0, 0, 0, 'h00));
    vecs.push_back(mk(0, 1, 'h05,     0, 0, 0,    0, 0,    1, 0, 0, 'h00));
    vecs.push_back(mk(0, 0, 0,        1, 1, 'h05, 0, 0,    0, 0, 1, 'h00));
    vecs.push_back(mk(0, 1, 'h05,     0, 0, 0,    0, 0,    1, 0, 0, 'h01));
    vecs.push_back(mk(0, 0, 0,        1, 1, 'h05, 1, 0,    0, 0, 0, 'h02));
    vecs.push_back(mk(0, 1, 'h05,     1, 1, 'h05, 1, 0,    1, 1, 0, 'h02));
    vecs.push_back(mk(0, 0, 0,        1, 1, 'h05, 1, 0,    0, 0, 0, 'h05));
    vecs.push_back(mk(0, 1, 'h05,     0, 0, 0,    0, 0,    1, 1, 0, 'h05));
    vecs.push_back(mk(0, 0, 0,        1, 0, 'h05, 1, 0,    0, 0, 1, 'h0B));
    vecs.push_back(mk(0, 1, 'h05,     0, 0, 0,    0, 0,    1, 1, 0, 'h00));
    vecs.push_back(mk(0, 1, 'h06,     0, 0, 0,    0, 0,    1, 1, 0, 'h01));
    vecs.push_back(mk(0, 1, 'h3FFF85, 0, 0, 0,    0, 0,    1, 1, 0, 'h03));
    vecs.push_back(mk(0, 0, 0,        1, 0, 'h05, 0, 0,    0, 0, 0, 'h07));
    vecs.push_back(mk(0, 0, 0,        1, 0, 'h05, 0, 0,    0, 0, 0, 'h07));
    vecs.push_back(mk(0, 1, 'h3FFF85, 0, 0, 0,    0, 0,    1, 0, 0, 'h07));
    vecs.push_back(mk(0, 0, 0,        1, 1, 'h10, 0, 'h55, 0, 0, 1, 'h0E));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,    0, 0,    0, 0, 0, 'h2B));
    vecs.push_back(mk(0, 1, 'h10,     0, 0, 0,    0, 0,    1, 1, 0, 'h2B));
    // gshare: speculative shift, repair priority, hashed indexing
    vecs.push_back(mk(1, 1, 'h10,     0, 0, 0,    0, 0,    1, 1, 0, 'h00));
    vecs.push_back(mk(1, 1, 'h11,     0, 0, 0,    0, 0,    1, 1, 0, 'h01));
    vecs.push_back(mk(1, 1, 'h12,     0, 0, 0,    0, 0,    1, 1, 0, 'h03));
    vecs.push_back(mk(1, 1, 'h13,     1, 0, 'h21, 1, 'h01, 1, 1, 1, 'h07));
    vecs.push_back(mk(1, 0, 0,        0, 0, 0,    0, 0,    0, 0, 0, 'h02));
    vecs.push_back(mk(1, 1, 'h22,     0, 0, 0,    0, 0,    1, 0, 0, 'h02));
    vecs.push_back(mk(1, 1, 'h24,     0, 0, 0,    0, 0,    1, 0, 0, 'h04));

    rst = 1'b1;
    init_stim();
    #1;
    check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_init("boot");

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      if (vecs[i].sel) begin
        in_g = vecs[i].d; in_b = '0;
      end else begin
        in_b = vecs[i].d; in_g = '0;
      end
      e.sel = vecs[i].sel; e.id = i;
      e.e_valid = vecs[i].e_valid; e.e_taken = vecs[i].e_taken;
      e.e_flush = vecs[i].e_flush; e.e_ghr = vecs[i].e_ghr;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d valid", e.id), e.sel ? valid_g : valid_b, e.e_valid);
      check($sformatf("vec%0d taken", e.id), e.sel ? taken_g : taken_b, e.e_taken);
      check($sformatf("vec%0d flush", e.id), e.sel ? flush_g : flush_b, e.e_flush);
      check($sformatf("vec%0d ghr", e.id), e.sel ? ghr_g : ghr_b, e.e_ghr);
    end
    @(posedge clk);
    #1;
    in_b = '0;
    in_g = '0;

    // Asynchronous reset in the middle of a RUN cycle.
    @(posedge clk);
    #1;
    init_stim();
    #2;
    check("pre-reset valid_b", valid_b, 1);
    check("pre-reset flush_b", flush_b, 1);
    rst = 1'b1;
    #1;
    check_zero("mid-run reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_init("rerun");

    for (int i = 0; i < 128; i++) begin
      @(posedge clk);
      #1;
      in_b = '0; in_b.f_br = 1'b1; in_b.f_pc = AW'(i);
      @(negedge clk);
      check($sformatf("reclear entry %0d taken", i), taken_b, 1);
    end
    @(posedge clk);
    #1;
    in_b = '0;
    in_g = '0; in_g.f_br = 1'b1; in_g.f_pc = AW'('h20);
    #2;
    check("reclear gshare entry 0x20 taken", taken_g, 1);
    @(posedge clk);
    #1;
    in_g = '0;

`ifdef BP_STATS_EN
    #2;
    check("stats after init branches", st_br_b, 0);
    check("stats after init mispredicts", st_mp_b, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_b = '0; in_b.a_br = 1'b1; in_b.a_out = i[0]; in_b.a_pc = AW'(i);
      in_b.a_pred = (i < 3) ? ~i[0] : i[0];
    end
    @(posedge clk);
    #1;
    in_b = '0;
    #2;
    check("stats branches", st_br_b, 10);
    check("stats mispredicts", st_mp_b, 3);
    rst = 1'b1;
    #1;
    check("stats reset branches", st_br_b, 0);
    check("stats reset mispredicts", st_mp_b, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
